// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes instruction descriptors and writes them sequentially into instruction memory
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [31:0]           word_q, word_d, enc;
    logic                  last_q, last_d, error_q, error_d, legal, full;

    assign legal     = in_kind <= 3'd4;
    assign full      = ptr_q == ADDR_WIDTH'(DEPTH - 1);
    assign in_ready  = state_q == ACCEPT;
    assign mem_we    = state_q == WRITE;
    assign mem_addr  = mem_we ? ptr_q : '0;
    assign mem_wdata = mem_we ? word_q : '0;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign error     = error_q;
    assign count     = count_q;

    // Build the instruction word for the presented descriptor kind
    always_comb begin
        enc = 32'h0;
        case (in_kind)
            3'd0:    enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1:    enc = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    enc = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    enc = {6'b000100, in_rs, in_rt, in_imm};
            3'd4:    enc = {6'b000010, in_target};
            default: enc = 32'h0;
        endcase
    end

    // Session sequencing: accept one descriptor, write it, repeat until last, full or illegal
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                ptr_d   = '0;
                count_d = '0;
                if (start) begin
                    error_d = 1'b0;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_valid && legal) begin
                    word_d  = enc;
                    last_d  = in_last;
                    state_d = WRITE;
                end else if (in_valid) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            WRITE: begin
                count_d = count_q + 1'b1;
                ptr_d   = full ? ptr_q : ptr_q + 1'b1;
                state_d = (last_q || full) ? DONE : ACCEPT;
                error_d = error_q | (!last_q && full);
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
            error_q <= error_d;
        end
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Encodes instruction descriptions into 32-bit single-cycle-core instruction words for R-type, LW, SW, BEQ and J. It writes them sequentially into instruction memory and produces exactly the opcode and field layout the core's control decoder consumes. A test driver or boot source feeds it over a valid/ready stream, and its write port drives the instruction memory's write side. One load session runs per `start` pulse.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; `DEPTH = 2**ADDR_WIDTH` words.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begins a session; honoured only in IDLE.
- `in_valid` in 1: descriptor valid.
- `in_ready` out 1: block accepts a descriptor this cycle.
- `in_kind` in 3: 0=R, 1=LW, 2=SW, 3=BEQ, 4=J; 5–7 illegal.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` in 5 each: register and shift fields.
- `in_funct` in 6: R-type function field.
- `in_imm` in 16: LW/SW offset, BEQ word offset, used as-is.
- `in_target` in 26: J target field.
- `in_last` in 1: marks the final descriptor of the session.
- `mem_we` out 1: instruction-memory write strobe.
- `mem_addr` out ADDR_WIDTH: word address.
- `mem_wdata` out 32: encoded instruction.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at session end.
- `error` out 1: sticky until the next accepted `start` or `reset`.
- `count` out ADDR_WIDTH+1: number of words written this session.

## Operation
- **Encoding:**
  - R: {6'b000000, rs, rt, rd, shamt, funct}
  - LW: {6'b100011, rs, rt, imm}
  - SW: {6'b101011, rs, rt, imm}
  - BEQ: {6'b000100, rs, rt, imm}
  - J: {6'b000010, target}
  - Fields unused by a kind are ignored.
- **FSM states:** IDLE, ACCEPT, WRITE, DONE.
- **IDLE:**
  - `start` → ACCEPT.
  - Clears the write pointer `ptr`, `count` and `error`.
- **ACCEPT:**
  - `in_ready` = 1.
  - On `in_valid` with a legal kind: register the encoded word and the last flag → WRITE.
  - On `in_valid` with an illegal kind: set `error`, write nothing → DONE.
- **WRITE:**
  - `mem_we` = 1, `mem_addr` = `ptr`, `mem_wdata` = registered word, for exactly one cycle.
  - At the edge: `ptr` and `count` increment.
  - Next state:
    - Registered last → DONE.
    - Else if `ptr` was DEPTH-1 (memory full) → set `error` → DONE.
    - Else → ACCEPT.
- **DONE:** `done` = 1 for one cycle → IDLE.
- `start` outside IDLE is ignored.
- `in_ready` is low in IDLE, WRITE and DONE. The source must hold its descriptor stable while `in_valid` is high and `in_ready` is low.
- `ptr` never wraps. No write ever occurs at an address already written in the same session.
- Reset mid-session: at the reset edge, state returns to IDLE. `mem_we` is low in the following cycle. Any partially loaded memory contents are left as-is.

## Timing
- **Reset values:**
  - `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - `busy` = 0, `done` = 0, `error` = 0, `count` = 0
  - state = IDLE
- `start` sampled at edge t → `in_ready` = 1 and `busy` = 1 in cycle t+1.
- Transfer at edge k → `mem_we` high during cycle k+1 → memory captures the word at edge k+2.
- `count` updates at edge k+2.
- Next `in_ready` in cycle k+2, giving a throughput of 1 word per 2 cycles.
- Last word written at edge w → `done` high in cycle w+1 → `busy` = 0 in cycle w+2.
- Illegal kind transferred at edge k → `done` and `error` both high in cycle k+1; no `mem_we`.
- `error` holds through IDLE until the next accepted `start`, when it clears at the same edge that enters ACCEPT.

## Test plan
- **Encoding and address sequencing.** Session of 5 descriptors, last on the fifth:
  - R rs=1 rt=2 rd=3 shamt=0 funct=0x20 → 0x00221820 @0
  - LW rs=29 rt=8 imm=4 → 0x8FA80004 @1
  - SW rs=29 rt=8 imm=8 → 0xAFA80008 @2
  - BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF @3
  - J target=0x0100000 → 0x08100000 @4
  - Expected: `done` pulse, `count` = 5, `error` = 0.
- **Handshake backpressure.** `in_valid` held high continuously → exactly one `mem_we` per two cycles. Each descriptor is written exactly once, and no accept occurs while `in_ready` = 0.
- **Illegal kind.** Second descriptor has kind=6 → only address 0 is written, `done` and `error` = 1 one cycle after the transfer, `count` = 1. A following `start` clears `error`.
- **Overflow, `ADDR_WIDTH` = 2.** Six descriptors with no last flag → writes at 0–3 only, `error` = 1, `done` pulse, `count` = 4. The fifth descriptor is never accepted.
- **Reset during a write.** Assert `reset` in the WRITE cycle of the third word → next cycle `mem_we` = 0 and all outputs are at reset values. A new session then restarts at `mem_addr` = 0.
- **Start while busy.** `start` pulsed during ACCEPT → no effect on `ptr` or `count`; the session completes normally.
